// File: rtl/adder_cg_arbiter.sv
// Round-robin arbiter sharing one clock-gated adder between two requesters.
// Owns the adder clock enable, returns captured results and counts gated cycles.
module adder_cg_arbiter #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned IDLE_CYCLES = 8,
    parameter int unsigned WAKE_CYCLES = 2,
    parameter int unsigned ADD_LAT     = 1
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             cin0,
    input  logic             cin1,
    output logic             gnt0,
    output logic             gnt1,
    input  logic             force_on,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    output logic             cg_en,
    input  logic [WIDTH-1:0] sum_in,
    input  logic             cout_in,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             gated,
    output logic [31:0]      gated_cnt
);

    localparam int unsigned IDLE_W = $clog2(IDLE_CYCLES + 1);
    localparam int unsigned WAKE_W = $clog2(WAKE_CYCLES + 1);
    localparam int unsigned LAT_W  = $clog2(ADD_LAT + 1);
    localparam int unsigned CNT_W  = 32;

    typedef enum logic [1:0] {
        GATED = 2'd0,
        WAKE  = 2'd1,
        ARB   = 2'd2,
        EXEC  = 2'd3
    } state_t;

    state_t            state, state_d;
    logic [WAKE_W-1:0] wake_cnt, wake_cnt_d;
    logic [IDLE_W-1:0] idle_cnt, idle_cnt_d;
    logic [LAT_W-1:0]  lat_cnt, lat_cnt_d;
    logic              last_gnt, last_gnt_d;
    logic              owner, owner_d;
    logic              pick1;

    logic              gnt0_d, gnt1_d;
    logic [WIDTH-1:0]  add_a_d, add_b_d;
    logic              add_cin_d;
    logic              cg_en_d;
    logic              rsp_valid_d, rsp_id_d, rsp_cout_d;
    logic [WIDTH-1:0]  rsp_sum_d;
    logic              gated_d;
    logic [CNT_W-1:0]  gated_cnt_d;

    // Requester 1 wins when alone, or on a tie when requester 0 was served last.
    assign pick1 = req1 & (~req0 | ~last_gnt);

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state     <= GATED;
            wake_cnt  <= '0;
            idle_cnt  <= '0;
            lat_cnt   <= '0;
            last_gnt  <= 1'b1;
            owner     <= 1'b0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            add_a     <= '0;
            add_b     <= '0;
            add_cin   <= 1'b0;
            cg_en     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            gated     <= 1'b1;
            gated_cnt <= '0;
        end else begin
            state     <= state_d;
            wake_cnt  <= wake_cnt_d;
            idle_cnt  <= idle_cnt_d;
            lat_cnt   <= lat_cnt_d;
            last_gnt  <= last_gnt_d;
            owner     <= owner_d;
            gnt0      <= gnt0_d;
            gnt1      <= gnt1_d;
            add_a     <= add_a_d;
            add_b     <= add_b_d;
            add_cin   <= add_cin_d;
            cg_en     <= cg_en_d;
            rsp_valid <= rsp_valid_d;
            rsp_id    <= rsp_id_d;
            rsp_sum   <= rsp_sum_d;
            rsp_cout  <= rsp_cout_d;
            gated     <= gated_d;
            gated_cnt <= gated_cnt_d;
        end
    end

    always_comb begin
        state_d     = state;
        wake_cnt_d  = wake_cnt;
        idle_cnt_d  = idle_cnt;
        lat_cnt_d   = lat_cnt;
        last_gnt_d  = last_gnt;
        owner_d     = owner;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        add_a_d     = add_a;
        add_b_d     = add_b;
        add_cin_d   = add_cin;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id;
        rsp_sum_d   = rsp_sum;
        rsp_cout_d  = rsp_cout;
        gated_cnt_d = gated_cnt;

        case (state)
            GATED: begin
                if (gated_cnt != '1) begin
                    gated_cnt_d = gated_cnt + CNT_W'(1);
                end
                if (req0 | req1 | force_on) begin
                    state_d    = WAKE;
                    wake_cnt_d = '0;
                end
            end
            WAKE: begin
                idle_cnt_d = '0;
                if (wake_cnt == WAKE_W'(WAKE_CYCLES - 1)) begin
                    state_d = ARB;
                end else begin
                    wake_cnt_d = wake_cnt + WAKE_W'(1);
                end
            end
            ARB: begin
                if (req0 | req1) begin
                    add_a_d    = pick1 ? a1 : a0;
                    add_b_d    = pick1 ? b1 : b0;
                    add_cin_d  = pick1 ? cin1 : cin0;
                    gnt0_d     = ~pick1;
                    gnt1_d     = pick1;
                    owner_d    = pick1;
                    last_gnt_d = pick1;
                    idle_cnt_d = '0;
                    lat_cnt_d  = '0;
                    state_d    = EXEC;
                end else if (force_on) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt == IDLE_W'(IDLE_CYCLES)) begin
                    state_d = GATED;
                end else begin
                    idle_cnt_d = idle_cnt + IDLE_W'(1);
                end
            end
            EXEC: begin
                // Result is taken on the edge ADD_LAT cycles after the operand edge.
                if (lat_cnt == LAT_W'(ADD_LAT - 1)) begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = owner;
                    rsp_sum_d   = sum_in;
                    rsp_cout_d  = cout_in;
                    state_d     = ARB;
                end else begin
                    lat_cnt_d = lat_cnt + LAT_W'(1);
                end
            end
            default: state_d = GATED;
        endcase

        cg_en_d = (state_d != GATED);
        gated_d = (state_d == GATED);
    end

endmodule

// File: tb/tb_adder_cg_arbiter.sv
// Bench for adder_cg_arbiter: directed scenarios plus random traffic checked
// every cycle against a transaction-level model of the controller.
module tb_adder_cg_arbiter;

    localparam int unsigned WIDTH       = 16;
    localparam int unsigned IDLE_CYCLES = 8;
    localparam int unsigned WAKE_CYCLES = 2;
    localparam int unsigned ADD_LAT     = 1;

    logic             clk = 1'b0;
    logic             reset_b = 1'b0;
    logic             req0 = 1'b0, req1 = 1'b0;
    logic [WIDTH-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic             cin0 = 1'b0, cin1 = 1'b0;
    logic             force_on = 1'b0;
    logic             gnt0, gnt1;
    logic [WIDTH-1:0] add_a, add_b;
    logic             add_cin, cg_en;
    logic [WIDTH-1:0] sum_in;
    logic             cout_in;
    logic             rsp_valid, rsp_id, rsp_cout, gated;
    logic [WIDTH-1:0] rsp_sum;
    logic [31:0]      gated_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    // Behavioural adder on the gated side.
    assign {cout_in, sum_in} = {1'b0, add_a} + {1'b0, add_b} + (WIDTH+1)'(add_cin);

    adder_cg_arbiter #(
        .WIDTH(WIDTH), .IDLE_CYCLES(IDLE_CYCLES),
        .WAKE_CYCLES(WAKE_CYCLES), .ADD_LAT(ADD_LAT)
    ) dut (
        .clk(clk), .reset_b(reset_b),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .cin0(cin0), .cin1(cin1),
        .gnt0(gnt0), .gnt1(gnt1),
        .force_on(force_on),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .cg_en(cg_en),
        .sum_in(sum_in), .cout_in(cout_in),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
        .gated(gated), .gated_cnt(gated_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: sleeping / waking / busy periods tracked as remaining-cycle counts.
    bit                 m_asleep, m_last, m_owner;
    int                 m_wake_left, m_busy_left, m_idle;
    logic [WIDTH-1:0]   e_a, e_b, e_sum;
    bit                 e_cin, e_cout, e_id, e_rv, e_g0, e_g1, e_cg, e_gated;
    longint unsigned    e_gcnt;

    task automatic model_reset();
        m_asleep = 1'b1; m_last = 1'b1; m_owner = 1'b0;
        m_wake_left = 0; m_busy_left = 0; m_idle = 0;
        e_a = '0; e_b = '0; e_cin = 1'b0; e_sum = '0; e_cout = 1'b0; e_id = 1'b0;
        e_rv = 1'b0; e_g0 = 1'b0; e_g1 = 1'b0; e_cg = 1'b0; e_gated = 1'b1;
        e_gcnt = 0;
    endtask

    task automatic model_step();
        bit               w1;
        logic [WIDTH:0]   s;
        e_g0 = 1'b0; e_g1 = 1'b0; e_rv = 1'b0;
        if (m_asleep) begin
            if (e_gcnt < 64'hFFFF_FFFF) e_gcnt++;
            if (req0 || req1 || force_on) begin
                m_asleep = 1'b0;
                m_wake_left = WAKE_CYCLES;
                m_idle = 0;
            end
        end else if (m_wake_left > 0) begin
            m_wake_left--;
        end else if (m_busy_left > 0) begin
            m_busy_left--;
            if (m_busy_left == 0) begin
                s = {1'b0, e_a} + {1'b0, e_b} + (WIDTH+1)'(e_cin);
                e_rv = 1'b1; e_id = m_owner;
                e_sum = s[WIDTH-1:0]; e_cout = s[WIDTH];
            end
        end else if (req0 || req1) begin
            w1 = (req0 && req1) ? !m_last : req1;
            e_a = w1 ? a1 : a0; e_b = w1 ? b1 : b0; e_cin = w1 ? cin1 : cin0;
            e_g0 = !w1; e_g1 = w1;
            m_last = w1; m_owner = w1;
            m_busy_left = ADD_LAT; m_idle = 0;
        end else if (force_on) begin
            m_idle = 0;
        end else if (m_idle >= int'(IDLE_CYCLES)) begin
            m_asleep = 1'b1;
        end else begin
            m_idle++;
        end
        e_cg = !m_asleep; e_gated = m_asleep;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset_b);
            if (!reset_b) model_reset();
            else model_step();
        end
    end

    // Cycle-by-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                check("cg_en", 32'(cg_en), 32'(e_cg));
                check("gated", 32'(gated), 32'(e_gated));
                check("gnt0", 32'(gnt0), 32'(e_g0));
                check("gnt1", 32'(gnt1), 32'(e_g1));
                check("rsp_valid", 32'(rsp_valid), 32'(e_rv));
                check("rsp_id", 32'(rsp_id), 32'(e_id));
                check("rsp_sum", 32'(rsp_sum), 32'(e_sum));
                check("rsp_cout", 32'(rsp_cout), 32'(e_cout));
                check("add_a", 32'(add_a), 32'(e_a));
                check("add_b", 32'(add_b), 32'(e_b));
                check("add_cin", 32'(add_cin), 32'(e_cin));
                check("gated_cnt", gated_cnt, 32'(e_gcnt));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_rsp(input bit id, input bit from_gated,
                            input logic [WIDTH-1:0] xs, input bit xc);
        int n = 0;
        int n_cg = -1;
        int n_gnt = -1;
        while (n < 200) begin
            tick();
            n++;
            if (cg_en && n_cg < 0) n_cg = n;
            if ((id ? gnt1 : gnt0) && n_gnt < 0) begin
                n_gnt = n;
                if (id) req1 = 1'b0; else req0 = 1'b0;
            end
            if (rsp_valid) break;
        end
        check("rsp_seen", 32'(rsp_valid), 32'd1);
        check("lat_gnt", 32'(n_gnt), from_gated ? 32'(WAKE_CYCLES + 2) : 32'd1);
        check("lat_rsp", 32'(n), from_gated ? 32'(WAKE_CYCLES + 2 + ADD_LAT) : 32'(1 + ADD_LAT));
        if (from_gated) check("lat_cg", 32'(n_cg), 32'd1);
        check("dir_id", 32'(rsp_id), 32'(id));
        check("dir_sum", 32'(rsp_sum), 32'(xs));
        check("dir_cout", 32'(rsp_cout), 32'(xc));
    endtask

    task automatic do_req(input bit id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input bit cin, input bit from_gated,
                          input logic [WIDTH-1:0] xs, input bit xc);
        if (id) begin a1 = a; b1 = b; cin1 = cin; req1 = 1'b1; end
        else    begin a0 = a; b0 = b; cin0 = cin; req0 = 1'b1; end
        wait_rsp(id, from_gated, xs, xc);
    endtask

    initial begin
        int n;
        int n_rsp;
        bit busy_phase;

        // Reset state and idle gated counting.
        repeat (2) tick();
        check("rst_cg", 32'(cg_en), 32'd0);
        check("rst_gated", 32'(gated), 32'd1);
        check("rst_gcnt", gated_cnt, 32'd0);
        check("rst_rsp", 32'(rsp_valid), 32'd0);
        check("rst_add_a", 32'(add_a), 32'd0);
        chk_on = 1'b1;
        reset_b = 1'b1;
        repeat (5) tick();
        check("idle_gcnt", gated_cnt, 32'd5);
        check("idle_cg", 32'(cg_en), 32'd0);
        check("idle_gated", 32'(gated), 32'd1);
        reset_b = 1'b0;
        #1;
        check("async_gcnt", gated_cnt, 32'd0);
        check("async_gated", 32'(gated), 32'd1);
        tick();
        reset_b = 1'b1;

        // Single requests: from GATED, then a carry-out from ARB.
        do_req(1'b0, 16'hA5A5, 16'h5A5A, 1'b0, 1'b1, 16'hFFFF, 1'b0);
        do_req(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);

        // Contention with both requests held.
        a0 = 16'h1707; b0 = 16'h2345; cin0 = 1'b0;
        a1 = 16'h0001; b1 = 16'h0001; cin1 = 1'b1;
        req0 = 1'b1; req1 = 1'b1;
        n = 0; n_rsp = 0;
        while (n_rsp < 4 && n < 200) begin
            tick();
            n++;
            if (rsp_valid) begin
                check("cont_id", 32'(rsp_id), 32'(n_rsp % 2));
                check("cont_sum", 32'(rsp_sum), (n_rsp % 2) ? 32'h0003 : 32'h3A4C);
                n_rsp++;
            end
        end
        check("cont_count", 32'(n_rsp), 32'd4);
        req0 = 1'b0; req1 = 1'b0;

        // Idle re-gate timing from ARB entry.
        for (int j = 1; j <= int'(IDLE_CYCLES) + 1; j++) begin
            tick();
            check("regate_cg", 32'(cg_en), 32'(j <= int'(IDLE_CYCLES)));
        end
        check("regate_gated", 32'(gated), 32'd1);

        // force_on wakes and keeps the clock running.
        force_on = 1'b1;
        for (int j = 0; j < 100; j++) begin
            tick();
            check("force_cg", 32'(cg_en), 32'd1);
            check("force_gated", 32'(gated), 32'd0);
        end
        force_on = 1'b0;

        // Reset during EXEC abandons the addition; held req0 is served after wake.
        a0 = 16'h1234; b0 = 16'h4321; cin0 = 1'b1; req0 = 1'b1;
        n = 0;
        while (!gnt0 && n < 20) begin
            tick();
            n++;
        end
        check("rexec_gnt", 32'(gnt0), 32'd1);
        reset_b = 1'b0;
        #1;
        check("rexec_rv", 32'(rsp_valid), 32'd0);
        check("rexec_gated", 32'(gated), 32'd1);
        check("rexec_cg", 32'(cg_en), 32'd0);
        check("rexec_add_a", 32'(add_a), 32'd0);
        tick();
        check("rexec_norsp", 32'(rsp_valid), 32'd0);
        tick();
        reset_b = 1'b1;
        wait_rsp(1'b0, 1'b1, 16'h5556, 1'b0);

        // Random traffic alternating busy and sparse phases.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            tick();
            busy_phase = ((cyc / 500) % 2) == 0;
            reset_b = ($urandom_range(0, 699) != 0);
            if (req0 && gnt0) req0 = 1'b0;
            else if (!req0 && $urandom_range(0, busy_phase ? 3 : 39) == 0) begin
                a0 = 16'($urandom); b0 = 16'($urandom); cin0 = 1'($urandom); req0 = 1'b1;
            end
            if (req1 && gnt1) req1 = 1'b0;
            else if (!req1 && $urandom_range(0, busy_phase ? 3 : 39) == 0) begin
                a1 = 16'($urandom); b1 = 16'($urandom); cin1 = 1'($urandom); req1 = 1'b1;
            end
            if ($urandom_range(0, 149) == 0) force_on = ~force_on;
        end
        reset_b = 1'b1;
        req0 = 1'b0; req1 = 1'b0; force_on = 1'b0;
        repeat (20) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/adder_cg_arbiter.md
Name: adder_cg_arbiter

Overview:
- Controller that shares one clock-gated 16-bit adder (registered sum/carry outputs) between two requesters.
- Round-robin arbitrates requests and drives the adder operand and carry inputs.
- Owns the adder's clock-gate enable: opens the clock on demand and closes it after a programmable idle window.
- Captures the adder result, returns it to the granted requester and counts gated cycles for power reporting.

Parameters:
- WIDTH, 16, operand/sum width.
- IDLE_CYCLES, 8, consecutive idle ARB cycles before re-gating (>=1).
- WAKE_CYCLES, 2, cycles the clock runs before the first issue after ungating (>=1).
- ADD_LAT, 1, adder latency in cycles from operand register to valid sum (>=1).

Ports:
- clk  in  1  system clock.
- reset_b  in  1  asynchronous active-low reset.
- req0 / req1  in  1  request from requester 0/1; held high until the matching gnt.
- a0, b0 / a1, b1  in  WIDTH  operands of requester 0/1; sampled at grant.
- cin0 / cin1  in  1  carry-in of requester 0/1.
- gnt0 / gnt1  out  1  one-cycle grant pulse; operands captured.
- force_on  in  1  inhibits gating and forces cg_en=1 while high.
- add_a, add_b  out  WIDTH  registered operands to the adder.
- add_cin  out  1  registered carry to the adder.
- cg_en  out  1  adder clock enable; 1 = clock running.
- sum_in  in  WIDTH  adder sum_out.
- cout_in  in  1  adder carry_out.
- rsp_valid  out  1  one-cycle result strobe.
- rsp_id  out  1  requester owning the result.
- rsp_sum  out  WIDTH  captured sum.
- rsp_cout  out  1  captured carry.
- gated  out  1  high while in GATED.
- gated_cnt  out  32  count of cycles spent in GATED; saturates at 0xFFFFFFFF.

Behaviour:
- Reset (async, reset_b=0):
  - State = GATED; cg_en=0; gated=1.
  - All other outputs 0, including gnt*, rsp_*, add_*, gated_cnt.
  - Round-robin pointer = "last granted 1", so requester 0 wins the first tie.
  - Reset mid-operation abandons the in-flight addition; no rsp_valid is produced for it.
- FSM states: GATED, WAKE, ARB, EXEC. All outputs are registered.
- GATED:
  - cg_en=0; gated_cnt increments every cycle.
  - (req0|req1|force_on) sampled high -> WAKE next cycle with cg_en=1.
- WAKE:
  - cg_en=1; wake counter runs WAKE_CYCLES cycles, then -> ARB.
  - Requests are not granted during WAKE.
- ARB:
  - cg_en=1.
  - If any req: register the winner's operands onto add_a/add_b/add_cin, pulse gnt of the winner next cycle, clear the idle counter, -> EXEC.
  - Winner selection: if both request, the one not granted last wins; if one requests, it wins.
  - No req: idle counter increments; on reaching IDLE_CYCLES with force_on=0 -> GATED (cg_en=0 the following cycle).
  - force_on=1 holds the idle counter at 0.
- EXEC:
  - Counts ADD_LAT cycles from the operand register edge.
  - At the terminating edge: sum_in/cout_in are captured into rsp_sum/rsp_cout, rsp_id is set to the granted requester, and rsp_valid pulses for exactly 1 cycle.
  - Then -> ARB.
  - Requests are ignored during EXEC. A requester may re-raise req the cycle after its gnt; back-to-back service is still round-robin.
- Latency:
  - From ARB: req sampled -> gnt cycle+1 -> rsp_valid cycle+1+ADD_LAT.
  - From GATED: add 1+WAKE_CYCLES cycles.
- Throughput: one addition per ADD_LAT+1 cycles.
- Arithmetic: WIDTH-bit sum plus carry, produced by the adder. The block passes the result through and never modifies it.
- add_* hold their last values between grants to avoid datapath toggling.
- force_on asserted in GATED wakes the block exactly like a request.
- rsp_* other than rsp_valid hold until the next capture.

Test Plan:
- Reset then idle: after reset_b rises with no req -> cg_en=0, gated=1, gated_cnt increments by 1 per cycle; assert reset_b=0 at an arbitrary point -> gated_cnt=0 and all outputs 0 immediately (async).
- Single req from GATED: req0, a0=16'hA5A5, b0=16'h5A5A, cin0=0 -> cg_en=1 one cycle later; gnt0 after WAKE_CYCLES+1 more cycles; rsp_valid with rsp_id=0, rsp_sum=16'hFFFF, rsp_cout=0 ADD_LAT cycles after gnt0.
- Carry: req1, a1=16'hFFFF, b1=16'h0001, cin1=0 -> rsp_sum=16'h0000, rsp_cout=1, rsp_id=1.
- Contention: req0 and req1 high together and held (a0=16'h1707, b0=16'h2345; a1=16'h0001, b1=16'h0001, cin1=1) -> grants alternate 0,1,0,1; responses are 16'h3A4C with id 0 and 16'h0003 with id 1 in order; no grant falls during EXEC.
- Idle re-gate: after the last response with no req -> cg_en drops exactly IDLE_CYCLES+1 cycles after entering ARB. With force_on=1 held for 100 cycles -> cg_en stays 1, gated stays 0.
- Reset mid-EXEC: assert reset_b=0 in the cycle after gnt0 -> no rsp_valid; state GATED. A req0 held across reset is serviced after the wake sequence.
